// File: rtl/keypad_scanner_if.sv
// Key interface between the keypad front end (master) and its consumers
// (slave): keypad matrix wires, the controller's one-hot digit bus, the
// start/clear buttons, and the binary key code and press event.
interface keypad_scanner_if;
  logic [2:0] col_n;      // column returns, active-low, bit 0 = left column
  logic [3:0] row_n;      // row drives, active-low, bit 0 = top row
  logic [9:0] keyboard;   // one-hot digit lines
  logic       startn;     // low while '#' is held
  logic       clearn;     // low while '*' is held
  logic       key_valid;  // a single key is debounced-held
  logic [3:0] key_code;   // 0-9, A='*', B='#', F=none
  logic       key_event;  // one-cycle pulse on a newly accepted key

  modport master (
    input  col_n,
    output row_n, keyboard, startn, clearn, key_valid, key_code, key_event
  );

  modport slave (
    output col_n,
    input  row_n, keyboard, startn, clearn, key_valid, key_code, key_event
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 telephone keypad one row at a time, collects a
// full 12-key frame, rejects multi-key frames, debounces across frames and
// presents the held key on the controller bus with registered outputs.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,   // clocks each row stays driven (>= 3)
  parameter int DEBOUNCE = 3    // identical frames needed to change key (>= 1)
) (
  input  logic                clk,
  input  logic                reset,
  keypad_scanner_if.master    kp
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE + 1);

  localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_ZERO = STAB_W'(0);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE);

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Key code for a snapshot bit position (row*3+col).
  function automatic logic [3:0] pos_code(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd5;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd7;
      4'd7:    code = 4'd8;
      4'd8:    code = 4'd9;
      4'd9:    code = KEY_STAR;
      4'd10:   code = 4'd0;
      4'd11:   code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Exactly one pressed key yields its code; none or several (ghosting) yield NONE.
  function automatic logic [3:0] frame_code(input logic [11:0] frame);
    logic [3:0] cnt;
    logic [3:0] idx;
    cnt = 4'd0;
    idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      cnt = cnt + {3'd0, frame[i]};
      idx = frame[i] ? 4'(i) : idx;
    end
    return (cnt == 4'd1) ? pos_code(idx) : KEY_NONE;
  endfunction

  // One-hot digit line for a key code; non-digits drive nothing.
  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    logic [9:0] lines;
    if (code <= 4'd9) begin
      lines = 10'd1 << code;
    end else begin
      lines = 10'd0;
    end
    return lines;
  endfunction

  // Registers
  logic [2:0]        r_col_s1;
  logic [2:0]        r_col_s2;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_row;
  logic [11:0]       r_snap;
  logic [3:0]        r_prev;
  logic [STAB_W-1:0] r_stab;
  state_t            r_state;
  logic [3:0]        r_key;
  logic [3:0]        r_row_n;
  logic [9:0]        r_keyboard;
  logic              r_startn;
  logic              r_clearn;
  logic              r_key_valid;
  logic [3:0]        r_key_code;
  logic              r_key_event;

  // Combinational next-state values
  logic              w_sample;
  logic              w_frame_end;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [1:0]        w_row_nxt;
  logic [2:0]        w_row_hits;
  logic [11:0]       w_snap_nxt;
  logic [3:0]        w_cand;
  logic [STAB_W-1:0] w_stab_nxt;
  logic [3:0]        w_prev_nxt;
  logic              w_accept;
  state_t            w_state_nxt;
  logic [3:0]        w_key_nxt;
  logic              w_event_nxt;

  assign w_sample    = (r_slot == SLOT_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);
  assign w_row_hits  = ~r_col_s2;
  assign w_cand      = frame_code(w_snap_nxt);

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_s1 <= 3'b111;
      r_col_s2 <= 3'b111;
    end else begin
      r_col_s1 <= kp.col_n;
      r_col_s2 <= r_col_s1;
    end
  end

  // Next slot/row: the row advances when the slot wraps, row 3 wraps to 0.
  always_comb begin
    w_slot_nxt = r_slot + SLOT_ONE;
    w_row_nxt  = r_row;
    if (w_sample) begin
      w_slot_nxt = SLOT_ZERO;
      w_row_nxt  = r_row + 2'd1;
    end else begin
      w_row_nxt  = r_row;
    end
  end

  // Scan counters and the registered one-cold row drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot  <= SLOT_ZERO;
      r_row   <= 2'd0;
      r_row_n <= 4'b1110;
    end else begin
      r_slot  <= w_slot_nxt;
      r_row   <= w_row_nxt;
      r_row_n <= ~(4'b0001 << w_row_nxt);
    end
  end

  // Snapshot with the current row's sample merged in, so frame end sees row 3.
  always_comb begin
    w_snap_nxt = r_snap;
    case (r_row)
      2'd0:    w_snap_nxt[2:0]  = w_row_hits;
      2'd1:    w_snap_nxt[5:3]  = w_row_hits;
      2'd2:    w_snap_nxt[8:6]  = w_row_hits;
      2'd3:    w_snap_nxt[11:9] = w_row_hits;
      default: w_snap_nxt       = r_snap;
    endcase
  end

  // Store the driven row's columns on its last slot cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= 12'd0;
    end else if (w_sample) begin
      r_snap <= w_snap_nxt;
    end else begin
      r_snap <= r_snap;
    end
  end

  // Frame-to-frame stability count and acceptance decision.
  always_comb begin
    w_stab_nxt = r_stab;
    w_prev_nxt = r_prev;
    w_accept   = 1'b0;
    if (w_frame_end) begin
      if (w_cand == r_prev) begin
        w_stab_nxt = (r_stab == STAB_MAX) ? r_stab : (r_stab + STAB_ONE);
      end else begin
        w_stab_nxt = STAB_ONE;
        w_prev_nxt = w_cand;
      end
      w_accept = (w_stab_nxt == STAB_MAX) && (w_cand != r_key);
    end else begin
      w_accept = 1'b0;
    end
  end

  // Debounce counter and previous-frame candidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stab <= STAB_ZERO;
      r_prev <= KEY_NONE;
    end else begin
      r_stab <= w_stab_nxt;
      r_prev <= w_prev_nxt;
    end
  end

  // Debounced-key FSM: idle, or holding a key; direct key-to-key moves allowed.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_event_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_cand != KEY_NONE)) begin
          w_state_nxt = ST_HELD;
          w_key_nxt   = w_cand;
          w_event_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (w_accept && (w_cand == KEY_NONE)) begin
          w_state_nxt = ST_IDLE;
          w_key_nxt   = KEY_NONE;
        end else if (w_accept) begin
          w_key_nxt   = w_cand;
          w_event_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_key_nxt   = KEY_NONE;
      end
    endcase
  end

  // FSM state and debounced key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_key   <= KEY_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
    end
  end

  // Registered output decode, updated on the same edge as the key itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keyboard  <= 10'd0;
      r_startn    <= 1'b1;
      r_clearn    <= 1'b1;
      r_key_valid <= 1'b0;
      r_key_code  <= KEY_NONE;
      r_key_event <= 1'b0;
    end else begin
      r_keyboard  <= digit_onehot(w_key_nxt);
      r_startn    <= (w_key_nxt != KEY_HASH);
      r_clearn    <= (w_key_nxt != KEY_STAR);
      r_key_valid <= (w_key_nxt != KEY_NONE);
      r_key_code  <= w_key_nxt;
      r_key_event <= w_event_nxt;
    end
  end

  assign kp.row_n     = r_row_n;
  assign kp.keyboard  = r_keyboard;
  assign kp.startn    = r_startn;
  assign kp.clearn    = r_clearn;
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.key_event = r_key_event;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix, a frame-level reference
// model checked every cycle, a vector table, hand-written corner sequences
// and a randomized phase.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;

  // Key code for matrix position row*3+col.
  localparam logic [3:0] POS_CODE [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                           4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] press = 12'd0;   // pressed keys, bit row*3+col

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a column reads low when a pressed key sits on a driven row.
  function automatic logic [2:0] col_from(input logic [3:0] rn, input logic [11:0] p);
    logic [2:0] c;
    c = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 3; cc++)
        if (!rn[r] && p[r*3+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign kp.col_n = col_from(kp.row_n, press);

  // Reference model state
  int          m_e;
  logic [11:0] m_hist [4];
  logic [11:0] m_snap;
  logic [3:0]  m_prev;
  logic [3:0]  m_key;
  int          m_stab;
  logic        m_event;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  bit any_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_cand(input logic [11:0] f);
    logic [3:0] c;
    c = 4'hF;
    if ($countones(f) == 1)
      for (int i = 0; i < 12; i++)
        if (f[i]) c = POS_CODE[i];
    return c;
  endfunction

  // Expected {row_n, keyboard, startn, clearn, key_valid, key_code, key_event}.
  function automatic logic [21:0] model_outs();
    logic [3:0] rn;
    logic [9:0] kb;
    rn = ~(4'b0001 << ((m_e / SD) % 4));
    kb = (m_key <= 4'd9) ? (10'd1 << m_key) : 10'd0;
    return {rn, kb, (m_key != 4'hB), (m_key != 4'hA), (m_key != 4'hF), m_key, m_event};
  endfunction

  // One clock: advance the model by the edge's rules, then compare the DUT.
  task automatic tick();
    logic [11:0] p;
    logic [11:0] h;
    logic        rs;
    logic [3:0]  cand;
    int          r;
    @(posedge clk);
    p  = press;
    rs = reset;
    #1;
    if (rs) begin
      m_e = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 12'd0;
      m_snap = 12'd0; m_prev = 4'hF; m_key = 4'hF; m_stab = 0; m_event = 1'b0;
    end else begin
      m_e++;
      m_hist[m_e % 4] = p;
      m_event = 1'b0;
      if (m_e % SD == 0) begin
        // columns reach the sampler two clocks after they were on the wires
        r = ((m_e - 1) / SD) % 4;
        h = m_hist[(m_e - 2) % 4];
        for (int c = 0; c < 3; c++) m_snap[r*3+c] = h[r*3+c];
        if (m_e % FRAME == 0) begin
          cand = model_cand(m_snap);
          if (cand == m_prev) begin
            if (m_stab < DB) m_stab++;
          end else begin
            m_stab = 1;
            m_prev = cand;
          end
          if (m_stab == DB && cand != m_key) begin
            m_event = (cand != 4'hF);
            m_key   = cand;
          end
        end
      end
    end
    check("model", {10'd0, kp.row_n, kp.keyboard, kp.startn, kp.clearn,
                    kp.key_valid, kp.key_code, kp.key_event}, {10'd0, model_outs()});
    if (kp.key_event) ev_cnt++;
    if (kp.key_valid) any_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ev_cnt = 0;
    any_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [11:0] keys;
    logic [3:0]  code;
    logic [9:0]  kb;
    logic        sn;
    logic        cn;
    logic        valid;
    int          events;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // keys, code, keyboard, startn, clearn, key_valid, events
    tbl[0]  = '{12'h010, 4'h5, 10'b0000100000, 1'b1, 1'b1, 1'b1, 1}; // 5
    tbl[1]  = '{12'h000, 4'hF, 10'b0000000000, 1'b1, 1'b1, 1'b0, 0}; // release
    tbl[2]  = '{12'h800, 4'hB, 10'b0000000000, 1'b0, 1'b1, 1'b1, 1}; // #
    tbl[3]  = '{12'h200, 4'hA, 10'b0000000000, 1'b1, 1'b0, 1'b1, 1}; // *
    tbl[4]  = '{12'h400, 4'h0, 10'b0000000001, 1'b1, 1'b1, 1'b1, 1}; // 0
    tbl[5]  = '{12'h003, 4'hF, 10'b0000000000, 1'b1, 1'b1, 1'b0, 0}; // 1+2
    tbl[6]  = '{12'h001, 4'h1, 10'b0000000010, 1'b1, 1'b1, 1'b1, 1}; // 1
    tbl[7]  = '{12'h100, 4'h9, 10'b1000000000, 1'b1, 1'b1, 1'b1, 1}; // 9
    tbl[8]  = '{12'h0C0, 4'hF, 10'b0000000000, 1'b1, 1'b1, 1'b0, 0}; // 7+8
    tbl[9]  = '{12'h004, 4'h3, 10'b0000001000, 1'b1, 1'b1, 1'b1, 1}; // 3
    tbl[10] = '{12'h020, 4'h6, 10'b0001000000, 1'b1, 1'b1, 1'b1, 1}; // 6
    tbl[11] = '{12'h008, 4'h4, 10'b0000010000, 1'b1, 1'b1, 1'b1, 1}; // 4
    tbl[12] = '{12'h080, 4'h8, 10'b0100000000, 1'b1, 1'b1, 1'b1, 1}; // 8
    tbl[13] = '{12'h002, 4'h2, 10'b0000000100, 1'b1, 1'b1, 1'b1, 1}; // 2
    tbl[14] = '{12'h040, 4'h7, 10'b0010000000, 1'b1, 1'b1, 1'b1, 1}; // 7
    tbl[15] = '{12'h040, 4'h7, 10'b0010000000, 1'b1, 1'b1, 1'b1, 0}; // 7 repeat

    // Reset values
    press = 12'd0;
    do_reset();
    check("reset_outs", {10'd0, kp.row_n, kp.keyboard, kp.startn, kp.clearn,
                         kp.key_valid, kp.key_code, kp.key_event},
          {10'd0, 4'b1110, 10'd0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0});

    // Vector table, each entry held for five frames
    for (int v = 0; v < 16; v++) begin
      press  = tbl[v].keys;
      ev_cnt = 0;
      run(5 * FRAME);
      check($sformatf("tbl%0d_outs", v),
            {15'd0, kp.keyboard, kp.startn, kp.clearn, kp.key_valid, kp.key_code},
            {15'd0, tbl[v].kb, tbl[v].sn, tbl[v].cn, tbl[v].valid, tbl[v].code});
      check($sformatf("tbl%0d_events", v), ev_cnt, tbl[v].events);
    end

    // Key 5 from reset release: nothing before edge 48, acceptance on it
    press = 12'h010;
    do_reset();
    run(47);
    check("k5_early_event", ev_cnt, 0);
    check("k5_early_valid", any_valid, 0);
    tick();
    check("k5_accept", {17'd0, kp.keyboard, kp.key_valid, kp.key_code, kp.key_event},
          {17'd0, 10'b0000100000, 1'b1, 4'h5, 1'b1});
    tick();
    check("k5_event_width", kp.key_event, 1'b0);

    // Release after acceptance
    press  = 12'd0;
    ev_cnt = 0;
    run(4 * FRAME);
    check("release_outs", {17'd0, kp.keyboard, kp.key_valid, kp.key_code},
          {17'd0, 10'd0, 1'b0, 4'hF});
    check("release_events", ev_cnt, 0);

    // '#' then '*'
    press = 12'h800;
    do_reset();
    run(5 * FRAME);
    check("hash_outs", {15'd0, kp.keyboard, kp.startn, kp.clearn, kp.key_valid, kp.key_code},
          {15'd0, 10'd0, 1'b0, 1'b1, 1'b1, 4'hB});
    check("hash_events", ev_cnt, 1);
    press  = 12'h200;
    ev_cnt = 0;
    run(5 * FRAME);
    check("star_outs", {15'd0, kp.keyboard, kp.startn, kp.clearn, kp.key_valid, kp.key_code},
          {15'd0, 10'd0, 1'b1, 1'b0, 1'b1, 4'hA});
    check("star_events", ev_cnt, 1);

    // Key 9 bouncing every 10 cycles for five frames, then steady
    press = 12'd0;
    do_reset();
    for (int t = 0; t < 5 * FRAME; t++) begin
      press = ((t / 10) % 2 == 1) ? 12'h100 : 12'd0;
      tick();
    end
    check("bounce_no_event", ev_cnt, 0);
    press = 12'h100;
    run(4 * FRAME);
    check("bounce_settled", {21'd0, kp.keyboard[9], kp.key_code}, {21'd0, 1'b1, 4'h9});
    check("bounce_events", ev_cnt, 1);

    // Keys 1 and 2 together, then release 2
    press = 12'h003;
    do_reset();
    run(5 * FRAME);
    check("ghost_events", ev_cnt, 0);
    check("ghost_valid", any_valid, 0);
    press = 12'h001;
    run(4 * FRAME);
    check("ghost_then_1", {27'd0, kp.key_valid, kp.key_code}, {27'd0, 1'b1, 4'h1});
    check("ghost_then_1_events", ev_cnt, 1);

    // Reset while key 0 is held and accepted
    press = 12'h400;
    do_reset();
    run(4 * FRAME);
    check("k0_held", {27'd0, kp.key_valid, kp.key_code}, {27'd0, 1'b1, 4'h0});
    do_reset();
    check("midhold_reset", {10'd0, kp.row_n, kp.keyboard, kp.startn, kp.clearn,
                            kp.key_valid, kp.key_code, kp.key_event},
          {10'd0, 4'b1110, 10'd0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0});
    run(47);
    check("k0_reaccept_early", ev_cnt, 0);
    tick();
    check("k0_reaccept", {27'd0, kp.key_event, kp.key_code}, {27'd0, 1'b1, 4'h0});

    // Randomized presses, ghosts, gaps and resets against the model
    for (int it = 0; it < 150; it++) begin
      int kind;
      int a;
      int b;
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 11);
      b    = (a + $urandom_range(1, 11)) % 12;
      if (kind == 0) begin
        press = 12'd0;
      end else if (kind == 1) begin
        press = (12'd1 << a) | (12'd1 << b);
      end else if (kind == 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        press = 12'd1 << a;
      end
      run($urandom_range(1, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
